// File: rtl/implication_queue.sv
// Implication queue: live assignment table plus BCP propagation FIFO.
// Optional per-class counters enabled by IMPLICATION_QUEUE_STATS_EN.
module implication_queue #(
    parameter int NUM_VARIABLE   = 128,
    parameter int VARIABLE_INDEX = $clog2(NUM_VARIABLE),
    parameter int QUEUE_DEPTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          imp_valid,
    output logic                          imp_ready,
    input  logic [VARIABLE_INDEX-1:0]     imp_variable,
    input  logic                          imp_value,
    input  logic                          dec_valid,
    input  logic [VARIABLE_INDEX-1:0]     dec_variable,
    input  logic                          dec_value,
    input  logic                          unassign_valid,
    input  logic [VARIABLE_INDEX-1:0]     unassign_variable,
    output logic                          prop_valid,
    input  logic                          prop_ready,
    output logic [VARIABLE_INDEX-1:0]     prop_variable,
    output logic                          prop_value,
    input  logic [VARIABLE_INDEX-1:0]     rd_variable,
    output logic                          rd_unassign,
    output logic                          rd_value,
    output logic                          conflict,
    output logic [VARIABLE_INDEX-1:0]     conflict_variable,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count
`ifdef IMPLICATION_QUEUE_STATS_EN
    ,
    output logic [15:0]                   stat_new,
    output logic [15:0]                   stat_dup,
    output logic [15:0]                   stat_conflict
`endif
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = VARIABLE_INDEX + 1;

    logic [NUM_VARIABLE-1:0]   assigned_q;
    logic [NUM_VARIABLE-1:0]   value_q;
    logic [EW-1:0]             fifo_q [QUEUE_DEPTH];
    logic [PW-1:0]             wr_ptr_q;
    logic [PW-1:0]             rd_ptr_q;
    logic [CW-1:0]             count_q;
    logic                      conflict_q;
    logic [VARIABLE_INDEX-1:0] conflict_var_q;

    logic                      full;
    logic                      unassign_take;
    logic                      dec_take;
    logic                      imp_take;
    logic                      req;
    logic [VARIABLE_INDEX-1:0] req_var;
    logic                      req_value;
    logic                      tgt_assigned;
    logic                      tgt_value;
    logic                      is_new;
    logic                      is_dup;
    logic                      is_conf;
    logic                      pop;

    assign full          = (count_q == CW'(QUEUE_DEPTH));
    assign unassign_take = unassign_valid & (count_q == '0);
    assign dec_take      = dec_valid & ~full & ~conflict_q;
    assign imp_ready     = ~full & ~conflict_q & ~dec_valid
                         & ~unassign_valid & ~clr;
    assign imp_take      = imp_valid & imp_ready;

    // Single table write port: unassign beats decision beats implication.
    always_comb begin
        req       = 1'b0;
        req_var   = imp_variable;
        req_value = imp_value;
        if (!clr && !unassign_take && dec_take) begin
            req       = 1'b1;
            req_var   = dec_variable;
            req_value = dec_value;
        end else if (imp_take) begin
            req = 1'b1;
        end
    end

    assign tgt_assigned = assigned_q[req_var];
    assign tgt_value    = value_q[req_var];
    assign is_new       = req & ~tgt_assigned;
    assign is_dup       = req & tgt_assigned & (tgt_value == req_value);
    assign is_conf      = req & tgt_assigned & (tgt_value != req_value);

    assign prop_valid    = (count_q != '0) & ~conflict_q;
    assign pop           = prop_valid & prop_ready;
    assign prop_variable = fifo_q[rd_ptr_q][EW-1:1];
    assign prop_value    = fifo_q[rd_ptr_q][0];

    assign rd_unassign       = ~assigned_q[rd_variable];
    assign rd_value          = value_q[rd_variable];
    assign conflict          = conflict_q;
    assign conflict_variable = conflict_var_q;
    assign queue_count       = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            assigned_q     <= '0;
            value_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            conflict_q     <= 1'b0;
            conflict_var_q <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) fifo_q[i] <= '0;
        end else if (clr) begin
            assigned_q     <= '0;
            value_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            conflict_q     <= 1'b0;
            conflict_var_q <= '0;
        end else begin
            if (unassign_take) begin
                assigned_q[unassign_variable] <= 1'b0;
                value_q[unassign_variable]    <= 1'b0;
            end else if (is_new) begin
                assigned_q[req_var] <= 1'b1;
                value_q[req_var]    <= req_value;
            end
            // A conflict discards pending propagation work.
            if (is_conf) begin
                conflict_q <= 1'b1;
                if (!conflict_q) conflict_var_q <= req_var;
                count_q  <= '0;
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (is_new) begin
                    fifo_q[wr_ptr_q] <= {req_var, req_value};
                    wr_ptr_q         <= wr_ptr_q + 1'b1;
                end
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + CW'(is_new) - CW'(pop);
            end
        end
    end

`ifdef IMPLICATION_QUEUE_STATS_EN
    logic imp_sel;
    assign imp_sel = imp_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_new      <= '0;
            stat_dup      <= '0;
            stat_conflict <= '0;
        end else if (clr) begin
            stat_new      <= '0;
            stat_dup      <= '0;
            stat_conflict <= '0;
        end else if (imp_sel) begin
            if (is_new && stat_new != 16'hFFFF) stat_new <= stat_new + 16'd1;
            if (is_dup && stat_dup != 16'hFFFF) stat_dup <= stat_dup + 16'd1;
            if (is_conf && stat_conflict != 16'hFFFF)
                stat_conflict <= stat_conflict + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_implication_queue.sv
// Bench for implication_queue: vector table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_implication_queue;

    localparam int NV = 128;
    localparam int VI = 7;
    localparam int QD = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          imp_valid = 1'b0;
    logic          imp_ready;
    logic [VI-1:0] imp_variable = '0;
    logic          imp_value = 1'b0;
    logic          dec_valid = 1'b0;
    logic [VI-1:0] dec_variable = '0;
    logic          dec_value = 1'b0;
    logic          unassign_valid = 1'b0;
    logic [VI-1:0] unassign_variable = '0;
    logic          prop_valid;
    logic          prop_ready = 1'b0;
    logic [VI-1:0] prop_variable;
    logic          prop_value;
    logic [VI-1:0] rd_variable = '0;
    logic          rd_unassign;
    logic          rd_value;
    logic          conflict;
    logic [VI-1:0] conflict_variable;
    logic [4:0]    queue_count;

    int total = 0;
    int bad = 0;

    implication_queue #(
        .NUM_VARIABLE(NV), .VARIABLE_INDEX(VI), .QUEUE_DEPTH(QD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .imp_valid(imp_valid), .imp_ready(imp_ready),
        .imp_variable(imp_variable), .imp_value(imp_value),
        .dec_valid(dec_valid), .dec_variable(dec_variable),
        .dec_value(dec_value),
        .unassign_valid(unassign_valid),
        .unassign_variable(unassign_variable),
        .prop_valid(prop_valid), .prop_ready(prop_ready),
        .prop_variable(prop_variable), .prop_value(prop_value),
        .rd_variable(rd_variable), .rd_unassign(rd_unassign),
        .rd_value(rd_value), .conflict(conflict),
        .conflict_variable(conflict_variable),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic idle();
        imp_valid = 1'b0; imp_variable = '0; imp_value = 1'b0;
        dec_valid = 1'b0; dec_variable = '0; dec_value = 1'b0;
        unassign_valid = 1'b0; unassign_variable = '0;
        prop_ready = 1'b0; clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit iv; int ivar; bit ival;
        bit dv; int dvar; bit dval;
        bit uv; int uvar;
        bit pr; bit cl; int rd;
        bit rdy; bit un; bit rv; bit pv; int pvar; bit pval;
        int cnt; bit cf; int cvar;
    } vec_t;

    vec_t tbl[18];

    // Reference model
    bit m_asg[32];
    bit m_val[32];
    int mq[$];
    bit m_cf;
    int m_cvar;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_asg[i] = 1'b0;
            m_val[i] = 1'b0;
        end
        mq.delete();
        m_cf = 1'b0;
        m_cvar = 0;
    endtask

    initial begin
        int exp_var[$];
        int exp_val[$];

        tbl[0]  = '{1,5,1, 0,0,0, 0,0, 0,0,5, 1,0,1,1,5,1,1,0,0};
        tbl[1]  = '{1,5,1, 0,0,0, 0,0, 0,0,5, 1,0,1,1,5,1,1,0,0};
        tbl[2]  = '{1,7,0, 0,0,0, 0,0, 0,0,7, 1,0,0,1,5,1,2,0,0};
        tbl[3]  = '{0,0,0, 0,0,0, 0,0, 1,0,7, 1,0,0,1,7,0,1,0,0};
        tbl[4]  = '{1,4,1, 1,3,0, 0,0, 0,0,3, 0,0,0,1,7,0,2,0,0};
        tbl[5]  = '{1,4,1, 0,0,0, 0,0, 0,0,4, 1,0,1,1,7,0,3,0,0};
        tbl[6]  = '{1,9,1, 0,0,0, 0,0, 1,0,9, 1,0,1,1,3,0,3,0,0};
        tbl[7]  = '{0,0,0, 0,0,0, 0,0, 1,0,3, 1,0,0,1,4,1,2,0,0};
        tbl[8]  = '{0,0,0, 0,0,0, 0,0, 1,0,4, 1,0,1,1,9,1,1,0,0};
        tbl[9]  = '{0,0,0, 0,0,0, 0,0, 1,0,9, 1,0,1,0,0,0,0,0,0};
        tbl[10] = '{0,0,0, 0,0,0, 1,3, 0,0,3, 0,1,0,0,0,0,0,0,0};
        tbl[11] = '{1,6,1, 0,0,0, 0,0, 0,0,6, 1,0,1,1,6,1,1,0,0};
        tbl[12] = '{0,0,0, 0,0,0, 1,6, 0,0,6, 0,0,1,1,6,1,1,0,0};
        tbl[13] = '{1,5,0, 0,0,0, 0,0, 0,0,5, 1,0,1,0,0,0,0,1,5};
        tbl[14] = '{1,9,0, 0,0,0, 0,0, 0,0,9, 0,0,1,0,0,0,0,1,5};
        tbl[15] = '{0,0,0, 1,9,0, 0,0, 0,0,9, 0,0,1,0,0,0,0,1,5};
        tbl[16] = '{0,0,0, 0,0,0, 0,0, 0,1,5, 0,1,0,0,0,0,0,0,0};
        tbl[17] = '{0,0,0, 0,0,0, 0,0, 0,0,9, 1,1,0,0,0,0,0,0,0};

        idle();
        #12;
        chk("reset_count", queue_count, 0);
        chk("reset_prop_valid", prop_valid, 0);
        chk("reset_prop_variable", prop_variable, 0);
        chk("reset_conflict", conflict, 0);
        chk("reset_conflict_variable", conflict_variable, 0);
        rst_n = 1'b1;
        #1;
        chk("reset_imp_ready", imp_ready, 1);
        chk("reset_rd_unassign", rd_unassign, 1);
        tick();

        // Table-driven directed vectors
        for (int i = 0; i < 18; i++) begin
            imp_valid = tbl[i].iv;
            imp_variable = VI'(tbl[i].ivar);
            imp_value = tbl[i].ival;
            dec_valid = tbl[i].dv;
            dec_variable = VI'(tbl[i].dvar);
            dec_value = tbl[i].dval;
            unassign_valid = tbl[i].uv;
            unassign_variable = VI'(tbl[i].uvar);
            prop_ready = tbl[i].pr;
            clr = tbl[i].cl;
            rd_variable = VI'(tbl[i].rd);
            #1;
            chk($sformatf("v%0d_imp_ready", i), imp_ready, tbl[i].rdy);
            tick();
            chk($sformatf("v%0d_rd_unassign", i), rd_unassign, tbl[i].un);
            chk($sformatf("v%0d_rd_value", i), rd_value, tbl[i].rv);
            chk($sformatf("v%0d_prop_valid", i), prop_valid, tbl[i].pv);
            if (tbl[i].pv) begin
                chk($sformatf("v%0d_prop_var", i), prop_variable, tbl[i].pvar);
                chk($sformatf("v%0d_prop_val", i), prop_value, tbl[i].pval);
            end
            chk($sformatf("v%0d_count", i), queue_count, tbl[i].cnt);
            chk($sformatf("v%0d_conflict", i), conflict, tbl[i].cf);
            chk($sformatf("v%0d_conflict_var", i), conflict_variable,
                tbl[i].cvar);
        end
        idle();

        // Fill to full, then pop while offering a 17th entry
        for (int i = 0; i < 16; i++) begin
            imp_valid = 1'b1;
            imp_variable = VI'(20 + i);
            imp_value = 1'((i >> 0) & 1);
            exp_var.push_back(20 + i);
            exp_val.push_back(i & 1);
            tick();
        end
        imp_variable = VI'(40);
        imp_value = 1'b1;
        #1;
        chk("full_count", queue_count, 16);
        chk("full_imp_ready", imp_ready, 0);
        prop_ready = 1'b1;
        #1;
        chk("full_pop_imp_ready", imp_ready, 0);
        tick();
        void'(exp_var.pop_front());
        void'(exp_val.pop_front());
        rd_variable = VI'(40);
        #1;
        chk("full_pop_count", queue_count, 15);
        chk("full_17th_unassigned", rd_unassign, 1);
        prop_ready = 1'b0;
        tick();
        exp_var.push_back(40);
        exp_val.push_back(1);
        imp_valid = 1'b0;
        #1;
        chk("refill_count", queue_count, 16);
        prop_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d_valid", k), prop_valid, 1);
            chk($sformatf("drain%0d_var", k), prop_variable, exp_var[k]);
            chk($sformatf("drain%0d_val", k), prop_value, exp_val[k]);
            tick();
        end
        chk("drain_count", queue_count, 0);
        chk("drain_prop_valid", prop_valid, 0);
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // Randomized traffic against the reference model
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            bit full_m;
            bit rdy_m;
            bit pop_m;
            bit req_m;
            int rv_;
            bit rval_;
            int rd_;

            imp_valid = ($urandom_range(99) < 60);
            imp_variable = VI'($urandom_range(31));
            imp_value = 1'($urandom_range(1));
            dec_valid = ($urandom_range(99) < 10);
            dec_variable = VI'($urandom_range(31));
            dec_value = 1'($urandom_range(1));
            unassign_valid = ($urandom_range(99) < 20);
            unassign_variable = VI'($urandom_range(31));
            prop_ready = ($urandom_range(99) < 55);
            clr = ($urandom_range(99) < 2);
            rd_ = $urandom_range(31);
            rd_variable = VI'(rd_);
            #1;

            full_m = (mq.size() == QD);
            rdy_m = !full_m && !m_cf && !dec_valid && !unassign_valid && !clr;
            chk("rnd_imp_ready", imp_ready, rdy_m);
            chk("rnd_rd_unassign", rd_unassign, !m_asg[rd_]);
            chk("rnd_rd_value", rd_value, m_asg[rd_] ? m_val[rd_] : 0);
            chk("rnd_prop_valid", prop_valid, (mq.size() > 0) && !m_cf);
            if (mq.size() > 0 && !m_cf) begin
                chk("rnd_prop_var", prop_variable, mq[0] >> 1);
                chk("rnd_prop_val", prop_value, mq[0] & 1);
            end
            chk("rnd_count", queue_count, mq.size());
            chk("rnd_conflict", conflict, m_cf);
            chk("rnd_conflict_var", conflict_variable, m_cvar);

            if (clr) begin
                model_reset();
            end else begin
                pop_m = (mq.size() > 0) && !m_cf && prop_ready;
                req_m = 1'b0;
                rv_ = 0;
                rval_ = 1'b0;
                if (unassign_valid && mq.size() == 0) begin
                    m_asg[unassign_variable] = 1'b0;
                    m_val[unassign_variable] = 1'b0;
                end else if (dec_valid && !full_m && !m_cf) begin
                    req_m = 1'b1;
                    rv_ = int'(dec_variable);
                    rval_ = dec_value;
                end else if (imp_valid && rdy_m) begin
                    req_m = 1'b1;
                    rv_ = int'(imp_variable);
                    rval_ = imp_value;
                end
                if (pop_m) void'(mq.pop_front());
                if (req_m) begin
                    if (!m_asg[rv_]) begin
                        m_asg[rv_] = 1'b1;
                        m_val[rv_] = rval_;
                        mq.push_back(rv_ * 2 + int'(rval_));
                    end else if (m_val[rv_] != rval_) begin
                        if (!m_cf) m_cvar = rv_;
                        m_cf = 1'b1;
                        mq.delete();
                    end
                end
            end
            tick();
        end
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // Asynchronous reset in the middle of activity
        imp_valid = 1'b1;
        imp_variable = VI'(11);
        imp_value = 1'b1;
        tick();
        imp_variable = VI'(12);
        imp_value = 1'b0;
        tick();
        imp_valid = 1'b0;
        rd_variable = VI'(11);
        #1;
        chk("pre_rst_count", queue_count, 2);
        chk("pre_rst_rd_unassign", rd_unassign, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", queue_count, 0);
        chk("async_rst_prop_valid", prop_valid, 0);
        chk("async_rst_rd_unassign", rd_unassign, 1);
        chk("async_rst_rd_value", rd_value, 0);
        chk("async_rst_imp_ready", imp_ready, 1);
        rst_n = 1'b1;
        tick();
        imp_valid = 1'b1;
        imp_variable = VI'(11);
        imp_value = 1'b1;
        tick();
        imp_value = 1'b0;
        tick();
        imp_valid = 1'b0;
        #1;
        chk("conf_before_rst", conflict, 1);
        chk("conf_var_before_rst", conflict_variable, 11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_conflict", conflict, 0);
        chk("async_rst_conflict_var", conflict_variable, 0);
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/implication_queue.md
Name: implication_queue

Overview:
- Receiver/consumer for the unit clause evaluator's implication outputs (implied_variable, new_assignment).
- Holds the live variable assignment table and serves it as a lookup port; this port feeds the unassign and assignment inputs of the partial SAT and unit clause evaluators.
- Classifies each incoming implication as new, duplicate or conflicting. New ones are committed to the table and queued FIFO for BCP.
- Also accepts decisions from the solver controller and backtrack unassigns.

Parameters:
- NUM_VARIABLE, 128, number of variables in the assignment table.
- VARIABLE_INDEX, $clog2(NUM_VARIABLE), variable index width.
- QUEUE_DEPTH, 16, propagation FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush: table all-unassigned, FIFO empty, conflict cleared
- imp_valid  in  1  implication offered, from the unit clause evaluator's is_unit_clause path
- imp_ready  out  1  implication accepted this cycle when imp_valid and imp_ready are both 1
- imp_variable  in  VARIABLE_INDEX  implied variable
- imp_value  in  1  implied polarity (new_assignment)
- dec_valid  in  1  decision assignment from the controller; one-cycle pulse
- dec_variable  in  VARIABLE_INDEX  decision variable
- dec_value  in  1  decision polarity
- unassign_valid  in  1  backtrack: clear one variable
- unassign_variable  in  VARIABLE_INDEX  variable to clear
- prop_valid  out  1  FIFO head valid
- prop_ready  in  1  consumer (clause feeder) pops the head
- prop_variable  out  VARIABLE_INDEX  head variable
- prop_value  out  1  head polarity
- rd_variable  in  VARIABLE_INDEX  lookup address
- rd_unassign  out  1  1 when rd_variable is unassigned
- rd_value  out  1  value of rd_variable; 0 when unassigned
- conflict  out  1  sticky conflict flag
- conflict_variable  out  VARIABLE_INDEX  variable of the first conflict
- queue_count  out  $clog2(QUEUE_DEPTH)+1  FIFO occupancy

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - all variables unassigned, all values 0;
  - FIFO empty: prop_valid=0, prop_variable=0, prop_value=0, queue_count=0;
  - conflict=0, conflict_variable=0;
  - imp_ready = 1 after reset, because the combinational term evaluates true.
- Lookup: rd_unassign and rd_value are combinational from table state. A table write at edge N is visible on lookup after edge N (no same-cycle bypass).
- Port arbitration, one table write per cycle, priority unassign > dec > imp:
  - imp_ready = !full & !conflict & !dec_valid & !unassign_valid & !clr.
  - dec_valid is legal only when !full and !conflict; otherwise it is ignored.
  - unassign_valid is legal only when the FIFO is empty; otherwise it is ignored.
- Implication or decision classification at the accepting edge:
  - target unassigned: write assigned=1 and the value; push {variable, value} to the FIFO.
  - assigned, same value: duplicate; no write, no push.
  - assigned, opposite value: conflict. Set conflict=1 and capture conflict_variable. No write, no push. The FIFO is flushed on the same edge.
- Conflict is sticky until clr. While set:
  - imp_ready=0 and prop_valid=0;
  - further conflicts do not overwrite conflict_variable.
- FIFO:
  - pop when prop_valid & prop_ready;
  - simultaneous push and pop allowed; count unchanged;
  - full means queue_count == QUEUE_DEPTH; no push while full, even if popping that cycle;
  - pointers wrap modulo QUEUE_DEPTH;
  - prop_* is registered; a push into an empty FIFO gives prop_valid=1 one cycle later.
- clr takes priority over all ports; effect is visible next cycle.
- Asynchronous reset mid-operation: all state returns to reset values immediately.

Optional Feature:
- Macro: IMPLICATION_QUEUE_STATS_EN.
- When defined, three extra outputs: stat_new, stat_dup, stat_conflict, each 16 bits.
  - Each is a saturating count (stops at 0xFFFF) of accepted new, duplicate and conflicting implications. Decisions are excluded.
  - All three clear on reset and on clr.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- After reset: imp var 5 value 1 accepted. Next cycle: rd_variable=5 gives rd_unassign=0, rd_value=1; prop_valid=1 with variable 5 value 1; queue_count=1.
- Var 5=1 assigned, imp var 5 value 1 -> dropped as duplicate; queue_count unchanged; conflict=0.
- Var 5=1 assigned, imp var 5 value 0 -> conflict=1, conflict_variable=5, queue_count=0, imp_ready=0. A later conflict on var 9 keeps conflict_variable=5. clr -> conflict=0 and var 5 unassigned.
- Push 16 distinct variables with prop_ready=0 -> queue_count=16, imp_ready=0. Pop one while offering a 17th -> the 17th is not accepted that cycle. Drain order matches push order across pointer wrap.
- dec_valid var 3 value 0 and imp_valid var 4 in the same cycle -> decision written and pushed, imp_ready=0. Var 4 is accepted the next cycle.
- FIFO empty, unassign_valid var 3 -> rd_unassign=1 for var 3 next cycle. Assert rst_n low mid-stream -> all outputs return to reset values immediately.
